// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types; the arbiter pulls its FSM encoding and core limit from here.
package cpu_types_pkg;

  localparam int ARB_CPUS_MAX = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DGRANT,
    ARB_IGRANT,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Stateless round-robin picker: first set req bit at or above ptr, wrapping N-1 -> 0.
// Purely combinational, no backpressure; the caller registers the result.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan from farthest offset down so the closest requester to ptr is the last write.
    for (int k = N - 1; k >= 0; k--) begin
      automatic int pos = (int'(ptr) + k) % N;
      if (req[pos]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the shared RAM/coherence bus: one registered one-hot grant (data or instr) at a time.
// Grant one edge after IDLE sees the request; txn_done, holder abort or HOLD_MAX timeout release via a one-cycle turnaround.
module coherence_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS       = 2,
  parameter int STARVE_LIM = 8,
  parameter int HOLD_MAX   = 64,
  localparam int IW        = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] dreq,
  input  logic [CPUS-1:0] ireq,
  input  logic            txn_done,
  output logic [CPUS-1:0] dgrant,
  output logic [CPUS-1:0] igrant,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic            timeout_err
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int HW = $clog2(HOLD_MAX);

  if (CPUS < 2 || CPUS > ARB_CPUS_MAX) begin : g_bad_cpus
    $error("coherence_bus_arbiter: CPUS out of range");
  end

  arb_state_t    state;
  logic [IW-1:0] d_ptr, i_ptr;
  logic [SW-1:0] starve_cnt;
  logic [HW-1:0] hold_cnt;

  logic            d_found, i_found;
  logic [IW-1:0]   d_idx, i_idx;
  logic [CPUS-1:0] d_onehot, i_onehot;

  rr_pick #(.N(CPUS), .W(IW)) u_pick_d (
    .req    (dreq),
    .ptr    (d_ptr),
    .found  (d_found),
    .idx    (d_idx),
    .onehot (d_onehot)
  );

  rr_pick #(.N(CPUS), .W(IW)) u_pick_i (
    .req    (ireq),
    .ptr    (i_ptr),
    .found  (i_found),
    .idx    (i_idx),
    .onehot (i_onehot)
  );

  logic          holder_req;
  logic          hold_last;
  logic          starved;
  logic [IW-1:0] next_ptr;

  always_comb begin
    holder_req = (state == ARB_DGRANT) ? dreq[grant_id] : ireq[grant_id];
    hold_last  = (hold_cnt == HW'(HOLD_MAX - 1));
    starved    = (starve_cnt == SW'(STARVE_LIM));
    next_ptr   = (grant_id == IW'(CPUS - 1)) ? '0 : grant_id + IW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= ARB_IDLE;
      dgrant      <= '0;
      igrant      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      d_ptr       <= '0;
      i_ptr       <= '0;
      starve_cnt  <= '0;
      hold_cnt    <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (|ireq && igrant == '0 && !starved) starve_cnt <= starve_cnt + SW'(1);

      case (state)
        ARB_IDLE: begin
          // A starved instruction fetch jumps ahead of pending data traffic.
          if (starved && i_found) begin
            igrant     <= i_onehot;
            grant_id   <= i_idx;
            busy       <= 1'b1;
            starve_cnt <= '0;
            state      <= ARB_IGRANT;
          end else if (d_found) begin
            dgrant   <= d_onehot;
            grant_id <= d_idx;
            busy     <= 1'b1;
            state    <= ARB_DGRANT;
          end else if (i_found) begin
            igrant     <= i_onehot;
            grant_id   <= i_idx;
            busy       <= 1'b1;
            starve_cnt <= '0;
            state      <= ARB_IGRANT;
          end
        end

        ARB_DGRANT, ARB_IGRANT: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (txn_done || !holder_req || hold_last) begin
            state       <= ARB_RELEASE;
            dgrant      <= '0;
            igrant      <= '0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
            timeout_err <= !txn_done && hold_last;
            if (state == ARB_DGRANT) d_ptr <= next_ptr;
            else                     i_ptr <= next_ptr;
          end
        end

        ARB_RELEASE: begin
          hold_cnt <= '0;
          state    <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
